// File: rtl/mmr_vector_voter_monitor_if.sv
// Bus bundle of the K-modular vector voter: replica words, voted word,
// per-replica health statistics and the statistics-clear handshake.
interface mmr_vector_voter_monitor_if #(
  parameter int unsigned K_MMR     = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [K_MMR-1:0][WIDTH-1:0] input_i;
  logic [WIDTH-1:0]            output_o;
  logic                        mismatch_o;
  logic [K_MMR-1:0]            replica_err_o;
  logic [K_MMR-1:0]            sticky_err_o;
  logic [K_MMR-1:0]            persistent_o;
  logic [K_MMR*CNT_WIDTH-1:0]  err_cnt_o;
  logic                        clr_req_i;
  logic                        clr_ack_o;

  modport master (
    output input_i, clr_req_i,
    input  output_o, mismatch_o, replica_err_o, sticky_err_o,
           persistent_o, err_cnt_o, clr_ack_o
  );

  modport slave (
    input  input_i, clr_req_i,
    output output_o, mismatch_o, replica_err_o, sticky_err_o,
           persistent_o, err_cnt_o, clr_ack_o
  );
endinterface

// File: rtl/mmr_vector_voter_monitor.sv
// Bitwise majority voter over K_MMR replicas with per-replica mismatch flags,
// saturating error counters, sticky/persistent fault flags and a req/ack clear.
module mmr_vector_voter_monitor #(
  parameter int unsigned K_MMR                 = 3,
  parameter int unsigned WIDTH                 = 8,
  parameter int unsigned MISMATCH_EN           = 1,
  parameter int unsigned G_MISMATCH_REGISTERED = 0,
  parameter int unsigned CNT_WIDTH             = 8,
  parameter int unsigned PERSIST_TH            = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mmr_vector_voter_monitor_if.slave bus
);
  localparam int unsigned VOTE_W = $clog2(K_MMR + 1);
  localparam int unsigned MAJ_TH = (K_MMR + 1) / 2;
  localparam int unsigned RUN_W  = 8;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [RUN_W-1:0]     RUN_TH   = RUN_W'(PERSIST_TH);
  localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(PERSIST_TH - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  if (!(K_MMR == 3 || K_MMR == 5)) begin : g_bad_k
    $error("mmr_vector_voter_monitor: K_MMR must be 3 or 5");
  end
  if (PERSIST_TH == 0 || PERSIST_TH > 255) begin : g_bad_th
    $error("mmr_vector_voter_monitor: PERSIST_TH must be in 1..255");
  end

  logic [WIDTH-1:0]                vote_c;
  logic [VOTE_W-1:0]               ones_c;
  logic [K_MMR-1:0]                err_c;
  logic [K_MMR-1:0]                rep_err;
  logic                            mis;
  logic [1:0]                      state;
  logic [1:0]                      state_nxt;
  logic                            clear_c;
  logic                            ack_q;
  logic [K_MMR-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [K_MMR-1:0][RUN_W-1:0]     run_q;
  logic [K_MMR-1:0]                sticky_q;
  logic [K_MMR-1:0]                pers_q;

  // Per-bit population count against the majority threshold.
  always_comb begin
    vote_c = '0;
    ones_c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones_c = '0;
      for (int r = 0; r < K_MMR; r++) begin
        ones_c = ones_c + VOTE_W'(bus.input_i[r][b]);
      end
      vote_c[b] = (ones_c >= VOTE_W'(MAJ_TH));
    end
  end

  always_comb begin
    err_c = '0;
    for (int r = 0; r < K_MMR; r++) begin
      err_c[r] = (bus.input_i[r] != vote_c);
    end
  end

  if (MISMATCH_EN == 0) begin : g_mis_off
    assign rep_err = '0;
    assign mis     = 1'b0;
  end else if (G_MISMATCH_REGISTERED == 0) begin : g_mis_comb
    assign rep_err = rst ? err_c : '0;
    assign mis     = rst & (|err_c);
  end else begin : g_mis_reg
    always_ff @(posedge clk) begin
      if (!rst) begin
        rep_err <= '0;
        mis     <= 1'b0;
      end else begin
        rep_err <= err_c;
        mis     <= |err_c;
      end
    end
  end

  // Clear handshake: one clear and one ack per rising request.
  always_comb begin
    state_nxt = state;
    clear_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req_i) begin
          state_nxt = ACK;
          clear_c   = 1'b1;
        end
      end
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!bus.clr_req_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state_nxt == ACK);
    end
  end

  // A clear on the same edge as an error wins; that error is dropped.
  always_ff @(posedge clk) begin
    if (!rst || clear_c) begin
      cnt_q    <= '0;
      run_q    <= '0;
      sticky_q <= '0;
      pers_q   <= '0;
    end else begin
      for (int r = 0; r < K_MMR; r++) begin
        if (err_c[r]) begin
          if (cnt_q[r] != CNT_MAX) cnt_q[r] <= cnt_q[r] + CNT_WIDTH'(1);
          if (run_q[r] != RUN_TH) run_q[r] <= run_q[r] + RUN_W'(1);
          if (run_q[r] == RUN_LAST) pers_q[r] <= 1'b1;
          sticky_q[r] <= 1'b1;
        end else begin
          run_q[r] <= '0;
        end
      end
    end
  end

  assign bus.output_o      = vote_c;
  assign bus.replica_err_o = rep_err;
  assign bus.mismatch_o    = mis;
  assign bus.sticky_err_o  = sticky_q;
  assign bus.persistent_o  = pers_q;
  assign bus.err_cnt_o     = cnt_q;
  assign bus.clr_ack_o     = ack_q;
endmodule

// File: tb/tb_mmr_vector_voter_monitor.sv
// Bench for the vector voter: three configurations driven in lockstep and
// compared against a behavioural model of the voting and statistics rules.
module tb_mmr_vector_voter_monitor;
  logic       clk;
  logic       rst;
  logic       clr_req;
  logic [7:0] w [5];

  int checks = 0;
  int errors = 0;

  // u0: K=3 comb flags, 4-bit counters; u1: K=5 registered flags; u2: K=3 flags off, TH=1
  int k_of  [3] = '{3, 5, 3};
  int cw_of [3] = '{4, 8, 8};
  int cmax  [3] = '{15, 255, 255};
  int th_of [3] = '{4, 4, 1};

  int         m_cnt    [3][5];
  int         m_run    [3][5];
  bit         m_sticky [3][5];
  bit         m_pers   [3][5];
  int         phase = 0;
  bit         m_ack = 1'b0;
  logic [4:0] m_regerr = '0;

  mmr_vector_voter_monitor_if #(.K_MMR(3), .WIDTH(8), .CNT_WIDTH(4)) ia ();
  mmr_vector_voter_monitor_if #(.K_MMR(5), .WIDTH(8), .CNT_WIDTH(8)) ib ();
  mmr_vector_voter_monitor_if #(.K_MMR(3), .WIDTH(8), .CNT_WIDTH(8)) ic ();

  assign ia.input_i   = {w[2], w[1], w[0]};
  assign ib.input_i   = {w[4], w[3], w[2], w[1], w[0]};
  assign ic.input_i   = {w[2], w[1], w[0]};
  assign ia.clr_req_i = clr_req;
  assign ib.clr_req_i = clr_req;
  assign ic.clr_req_i = clr_req;

  mmr_vector_voter_monitor #(
    .K_MMR(3), .WIDTH(8), .MISMATCH_EN(1), .G_MISMATCH_REGISTERED(0),
    .CNT_WIDTH(4), .PERSIST_TH(4)
  ) u0 (.clk(clk), .rst(rst), .bus(ia));

  mmr_vector_voter_monitor #(
    .K_MMR(5), .WIDTH(8), .MISMATCH_EN(1), .G_MISMATCH_REGISTERED(1),
    .CNT_WIDTH(8), .PERSIST_TH(4)
  ) u1 (.clk(clk), .rst(rst), .bus(ib));

  mmr_vector_voter_monitor #(
    .K_MMR(3), .WIDTH(8), .MISMATCH_EN(0), .G_MISMATCH_REGISTERED(0),
    .CNT_WIDTH(8), .PERSIST_TH(1)
  ) u2 (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] v;   // {w4, w3, w2, w1, w0}
    logic [7:0]  o3;
    logic [2:0]  e3;
    logic [7:0]  o5;
    logic [4:0]  e5;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Sel: 0 output, 1 replica_err, 2 mismatch, 3 sticky, 4 persistent, 5 err_cnt, 6 ack
  function automatic logic [63:0] act(input int i, input int s);
    case (i)
      0: case (s)
           0: return 64'(ia.output_o);     1: return 64'(ia.replica_err_o);
           2: return 64'(ia.mismatch_o);   3: return 64'(ia.sticky_err_o);
           4: return 64'(ia.persistent_o); 5: return 64'(ia.err_cnt_o);
           default: return 64'(ia.clr_ack_o);
         endcase
      1: case (s)
           0: return 64'(ib.output_o);     1: return 64'(ib.replica_err_o);
           2: return 64'(ib.mismatch_o);   3: return 64'(ib.sticky_err_o);
           4: return 64'(ib.persistent_o); 5: return 64'(ib.err_cnt_o);
           default: return 64'(ib.clr_ack_o);
         endcase
      default: case (s)
           0: return 64'(ic.output_o);     1: return 64'(ic.replica_err_o);
           2: return 64'(ic.mismatch_o);   3: return 64'(ic.sticky_err_o);
           4: return 64'(ic.persistent_o); 5: return 64'(ic.err_cnt_o);
           default: return 64'(ic.clr_ack_o);
         endcase
    endcase
  endfunction

  function automatic logic [7:0] ref_maj(input int k);
    logic [7:0] m = '0;
    for (int b = 0; b < 8; b++) begin
      int c = 0;
      for (int r = 0; r < k; r++) c += int'(w[r][b]);
      m[b] = (2 * c > k);
    end
    return m;
  endfunction

  function automatic logic [4:0] ref_err(input int k);
    logic [4:0] e = '0;
    logic [7:0] m = ref_maj(k);
    for (int r = 0; r < k; r++) e[r] = (w[r] != m);
    return e;
  endfunction

  function automatic logic [63:0] exp_stat(input int i, input int s);
    logic [63:0] x = '0;
    for (int r = 0; r < k_of[i]; r++) begin
      case (s)
        3:       x[r] = m_sticky[i][r];
        4:       x[r] = m_pers[i][r];
        default: x = x | (64'(m_cnt[i][r]) << (r * cw_of[i]));
      endcase
    end
    return x;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit clear;
    logic [4:0] e;
    clear = rst && phase == 0 && clr_req;
    for (int i = 0; i < 3; i++) begin
      e = ref_err(k_of[i]);
      for (int r = 0; r < k_of[i]; r++) begin
        if (!rst || clear) begin
          m_cnt[i][r] = 0; m_run[i][r] = 0; m_sticky[i][r] = 0; m_pers[i][r] = 0;
        end else if (e[r]) begin
          if (m_cnt[i][r] < cmax[i]) m_cnt[i][r]++;
          if (m_run[i][r] < th_of[i]) m_run[i][r]++;
          if (m_run[i][r] == th_of[i]) m_pers[i][r] = 1;
          m_sticky[i][r] = 1;
        end else begin
          m_run[i][r] = 0;
        end
      end
    end
    m_regerr = rst ? ref_err(5) : 5'b0;
    if (!rst) phase = 0;
    else if (phase == 0) begin if (clr_req) phase = 1; end
    else if (phase == 1) phase = 2;
    else if (!clr_req) phase = 0;
    m_ack = (phase == 1);
  endtask

  // Called at posedge+1 (inputs already set); returns at the next posedge+1.
  task automatic tick();
    logic [4:0] er;
    #4;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       er = rst ? ref_err(3) : 5'b0;
        1:       er = m_regerr;
        default: er = 5'b0;
      endcase
      chk($sformatf("u%0d_output", i), act(i, 0), 64'(ref_maj(k_of[i])));
      chk($sformatf("u%0d_replica_err", i), act(i, 1), 64'(er));
      chk($sformatf("u%0d_mismatch", i), act(i, 2), 64'(|er));
    end
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_sticky", i), act(i, 3), exp_stat(i, 3));
      chk($sformatf("u%0d_persistent", i), act(i, 4), exp_stat(i, 4));
      chk($sformatf("u%0d_err_cnt", i), act(i, 5), exp_stat(i, 5));
      chk($sformatf("u%0d_ack", i), act(i, 6), 64'(m_ack));
    end
  endtask

  task automatic set_w(input logic [7:0] a, b, c, d, e);
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int acks;
    tbl[0] = '{v: 40'hA5A5A5A5A5, o3: 8'hA5, e3: 3'b000, o5: 8'hA5, e5: 5'b00000};
    tbl[1] = '{v: 40'hA5A524A5A5, o3: 8'hA5, e3: 3'b100, o5: 8'hA5, e5: 5'b00100};
    tbl[2] = '{v: 40'hFFF00F00FF, o3: 8'h0F, e3: 3'b011, o5: 8'hFF, e5: 5'b01110};
    tbl[3] = '{v: 40'hFFFF000000, o3: 8'h00, e3: 3'b000, o5: 8'h00, e5: 5'b11000};
    tbl[4] = '{v: 40'h0703040201, o3: 8'h00, e3: 3'b111, o5: 8'h03, e5: 5'b10111};
    tbl[5] = '{v: 40'h5AC3C35A5A, o3: 8'h5A, e3: 3'b100, o5: 8'h5A, e5: 5'b01100};

    rst = 1'b0;
    clr_req = 1'b0;
    set_w(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Hand-computed vote vectors.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 5; r++) w[r] = tbl[i].v[r*8 +: 8];
      #2;
      chk("tbl_out3", act(0, 0), 64'(tbl[i].o3));
      chk("tbl_err3", act(0, 1), 64'(tbl[i].e3));
      chk("tbl_out5", act(1, 0), 64'(tbl[i].o5));
      tick();
      chk("tbl_err5_reg", act(1, 1), 64'(tbl[i].e5));
      chk("tbl_mis5_reg", act(1, 2), 64'(|tbl[i].e5));
    end

    // One deviant replica held for three cycles.
    set_w(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    do_reset();
    tick();
    set_w(8'hA5, 8'hA5, 8'h24, 8'hA5, 8'hA5);
    #1;
    chk("dev_err_same_cycle", act(0, 1), 64'h4);
    chk("dev_reg_err_not_yet", act(1, 1), 64'h0);
    tick();
    chk("dev_reg_err_next", act(1, 1), 64'h4);
    tick();
    tick();
    chk("dev_cnt_k3", act(0, 5), 64'h300);
    chk("dev_cnt_k5", act(1, 5), 64'h30000);
    chk("dev_sticky_k3", act(0, 3), 64'h4);

    // Persistence needs an unbroken run.
    set_w(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    set_w(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    set_w(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("pers_after_break", act(1, 4), 64'h0);
    set_w(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("pers_third_edge", act(1, 4), 64'h0);
    tick();
    chk("pers_fourth_edge", act(1, 4), 64'h2);
    chk("pers_cnt_k5", act(1, 5), 64'h700);
    chk("pers_cnt_k3", act(0, 5), 64'h70);

    // Counter saturation with 4-bit counters.
    set_w(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    set_w(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (20) tick();
    chk("sat_cnt4", act(0, 5), 64'hF);
    chk("sat_cnt8", act(1, 5), 64'h14);

    // Clear held high while replica 2 errs on the request edge.
    set_w(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
    clr_req = 1'b1;
    tick();
    chk("clr_ack", act(0, 6), 64'h1);
    chk("clr_cnt", act(0, 5), 64'h0);
    chk("clr_sticky", act(0, 3), 64'h0);
    acks = 1;
    tick();
    chk("clr_resume", act(0, 5), 64'h100);
    repeat (3) begin
      tick();
      acks += int'(act(0, 6));
    end
    chk("clr_single_ack", 64'(acks), 64'h1);
    clr_req = 1'b0;
    tick();
    clr_req = 1'b1;
    tick();
    chk("clr_second_ack", act(0, 6), 64'h1);

    // Reset while in ACK with active errors, request still high.
    rst = 1'b0;
    tick();
    chk("rst_ack", act(0, 6), 64'h0);
    chk("rst_cnt_k3", act(0, 5), 64'h0);
    chk("rst_cnt_k5", act(1, 5), 64'h0);
    rst = 1'b1;
    tick();
    chk("rst_reclear_ack", act(0, 6), 64'h1);
    chk("rst_reclear_cnt", act(0, 5), 64'h0);
    clr_req = 1'b0;
    repeat (2) tick();

    // Random agreement/disagreement mix with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] base;
      base = 8'($urandom);
      for (int r = 0; r < 5; r++) begin
        w[r] = ($urandom_range(0, 2) == 0) ? (base ^ 8'($urandom)) : base;
      end
      if ($urandom_range(0, 7) == 0) clr_req = ~clr_req;
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
